// File: rtl/ddrphy_pwr_sane_core.sv
// ddrphy_pwr_sane_core: debounced supply sniffer (VddIn,VddOut->VddInOk), set-dominant sane flag (SetPulse,ClrN->Sane), pwr-ok gated inverting shifters (LsPwrOk,LsIn->LsOut_l); Clk, sync Reset
module ddrphy_pwr_sane_core #(
  parameter int DEBOUNCE = 4,
  parameter int LS_WIDTH = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                VddIn,
  input  logic                VddOut,
  output logic                VddInOk,
  input  logic                SetPulse,
  input  logic                ClrN,
  output logic                Sane,
  input  logic                LsPwrOk,
  input  logic [LS_WIDTH-1:0] LsIn,
  output logic [LS_WIDTH-1:0] LsOut_l
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE);
  logic          q;
  logic [CW-1:0] cnt, cnt_inc;
  always_comb begin
    q       = VddIn & VddOut;
    cnt_inc = (cnt == LIM) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= '0;
      VddInOk <= 1'b0;
      Sane    <= 1'b0;
      LsOut_l <= '0;
    end else begin
      cnt     <= q ? cnt_inc : '0;
      VddInOk <= q && (cnt_inc == LIM);
      Sane    <= !VddOut ? 1'b0 : SetPulse ? 1'b1 : !ClrN ? 1'b0 : Sane;
      LsOut_l <= LsPwrOk ? ~LsIn : '0;
    end
  end
endmodule

// File: tb/tb_ddrphy_pwr_sane_core.sv
// tb_ddrphy_pwr_sane_core: randomized scoreboard bench against a run-length reference model
module tb_ddrphy_pwr_sane_core;
  localparam int DEBOUNCE = 4;
  localparam int LS_WIDTH = 2;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic VddIn = 1'b0, VddOut = 1'b0, SetPulse = 1'b0, ClrN = 1'b1, LsPwrOk = 1'b0;
  logic [LS_WIDTH-1:0] LsIn = '0;
  logic VddInOk, Sane;
  logic [LS_WIDTH-1:0] LsOut_l;
  ddrphy_pwr_sane_core #(.DEBOUNCE(DEBOUNCE), .LS_WIDTH(LS_WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .VddIn(VddIn), .VddOut(VddOut), .VddInOk(VddInOk),
    .SetPulse(SetPulse), .ClrN(ClrN), .Sane(Sane), .LsPwrOk(LsPwrOk), .LsIn(LsIn),
    .LsOut_l(LsOut_l)
  );
  always #5 Clk = ~Clk;
  int vectors = 0;
  int errs = 0;
  int run = 0;
  logic m_sane = 1'b0;
  logic [LS_WIDTH-1:0] m_ls = '0;
  logic [LS_WIDTH+1:0] exp_q[$];
  task automatic step(input logic r, vi, vo, sp, cn, lp, input logic [LS_WIDTH-1:0] li);
    @(negedge Clk);
    Reset = r; VddIn = vi; VddOut = vo; SetPulse = sp; ClrN = cn; LsPwrOk = lp; LsIn = li;
    if (r) begin
      run = 0; m_sane = 1'b0; m_ls = '0;
    end else begin
      run = (vi && vo) ? run + 1 : 0;
      if (!vo) m_sane = 1'b0;
      else if (sp) m_sane = 1'b1;
      else if (!cn) m_sane = 1'b0;
      m_ls = lp ? ~li : '0;
    end
    exp_q.push_back({run >= DEBOUNCE, m_sane, m_ls});
    vectors++;
  endtask
  always @(posedge Clk) begin
    logic [LS_WIDTH+1:0] e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {VddInOk, Sane, LsOut_l};
      if (g !== e) begin
        errs++;
        $display("FAIL outs t=%0t got ok/sane/ls=%b/%b/%b expected %b/%b/%b", $time,
                 g[LS_WIDTH+1], g[LS_WIDTH], g[LS_WIDTH-1:0], e[LS_WIDTH+1], e[LS_WIDTH], e[LS_WIDTH-1:0]);
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 1, 0, 2'b00);
    step(1, 0, 0, 0, 1, 0, 2'b00);
    for (int i = 0; i < 300; i++) step(0, 1, 1, 0, 1, 0, 2'b01);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 0, 1, 0, 1, 0, 2'b01);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 0, 1, 0, 1, 0, 2'b01);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 1, 0, 0, 1, 0, 2'b01);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 1, 1, 1, 1, 0, 2'b01);
    step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 1, 1, 0, 0, 0, 2'b01);
    step(0, 1, 1, 1, 0, 0, 2'b01);
    step(0, 1, 0, 1, 1, 0, 2'b01);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 1, 0, 2'b01);
    step(0, 1, 1, 1, 1, 1, 2'b01);
    step(0, 1, 1, 0, 1, 1, 2'b11);
    step(0, 1, 1, 0, 1, 1, 2'b01);
    step(1, 1, 1, 0, 1, 1, 2'b01);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 1, 1, 2'b01);
    step(0, 1, 1, 1, 1, 1, 2'b10);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           LS_WIDTH'($urandom));
    @(negedge Clk);
    @(negedge Clk);
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
